// File: rtl/dfr_reservoir_sequencer.sv
// Reservoir sequencer: per sample and virtual node, forms masked input plus scaled
// delayed feedback, runs one ASIC conversion and streams the result to reservoir memory.
module dfr_reservoir_sequencer #(
   parameter int NUM_VIRTUAL_NODES = 10,
   parameter int FEEDBACK_SHIFT    = 1,
   parameter int ADDR_WIDTH        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  run,
   input  logic [ADDR_WIDTH-1:0] num_samples,
   output logic [ADDR_WIDTH-1:0] sample_addr,
   input  logic [15:0]           sample_data,
   output logic [7:0]            mask_addr,
   input  logic [15:0]           mask_data,
   output logic                  asic_start,
   output logic [15:0]           asic_data_in,
   input  logic                  asic_ready,
   input  logic [15:0]           asic_data_out,
   output logic                  res_wr_en,
   output logic [31:0]           res_wr_addr,
   output logic [15:0]           res_wr_data,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_FETCH_WAIT, S_COMPUTE, S_ISSUE,
      S_ACK_WAIT, S_RESULT_WAIT, S_WRITE, S_DONE
   } state_t;

   localparam logic [7:0] LAST_NODE = 8'(NUM_VIRTUAL_NODES - 1);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] s_q, s_d, num_q, num_d;
   logic [7:0]            n_q, n_d;
   logic [31:0]           wr_addr_q, wr_addr_d;
   logic                  fb_clr;
   logic [15:0]           fb_q [NUM_VIRTUAL_NODES];
   logic [15:0]           fb_sel;
   logic [31:0]           product;
   logic [16:0]           sum17;
   logic [15:0]           sat16;

   logic [ADDR_WIDTH-1:0] sample_addr_q, sample_addr_d;
   logic [7:0]            mask_addr_q, mask_addr_d;
   logic                  asic_start_q, asic_start_d;
   logic [15:0]           asic_data_in_q, asic_data_in_d;
   logic                  res_wr_en_q, res_wr_en_d;
   logic [31:0]           res_wr_addr_q, res_wr_addr_d;
   logic [15:0]           res_wr_data_q, res_wr_data_d;
   logic                  busy_q, busy_d, done_q, done_d;

   // Delay line: node n of the previous sample feeds node n of the current one
   for (genvar gi = 0; gi < NUM_VIRTUAL_NODES; gi++) begin : g_fb
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            fb_q[gi] <= '0;
         else if (fb_clr)
            fb_q[gi] <= '0;
         else if (state_q == S_WRITE && n_q == 8'(gi))
            fb_q[gi] <= res_wr_data_q;
      end
   end

   always_comb begin
      fb_sel = '0;
      for (int i = 0; i < NUM_VIRTUAL_NODES; i++)
         if (n_q == 8'(i)) fb_sel = fb_q[i];
   end

   assign product = 32'(sample_data) * 32'(mask_data);
   assign sum17   = {1'b0, product[31:16]} + {1'b0, fb_sel >> FEEDBACK_SHIFT};
   assign sat16   = sum17[16] ? 16'hFFFF : sum17[15:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         s_q            <= '0;
         n_q            <= '0;
         num_q          <= '0;
         wr_addr_q      <= '0;
         sample_addr_q  <= '0;
         mask_addr_q    <= '0;
         asic_start_q   <= 1'b0;
         asic_data_in_q <= '0;
         res_wr_en_q    <= 1'b0;
         res_wr_addr_q  <= '0;
         res_wr_data_q  <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         s_q            <= s_d;
         n_q            <= n_d;
         num_q          <= num_d;
         wr_addr_q      <= wr_addr_d;
         sample_addr_q  <= sample_addr_d;
         mask_addr_q    <= mask_addr_d;
         asic_start_q   <= asic_start_d;
         asic_data_in_q <= asic_data_in_d;
         res_wr_en_q    <= res_wr_en_d;
         res_wr_addr_q  <= res_wr_addr_d;
         res_wr_data_q  <= res_wr_data_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      s_d       = s_q;
      n_d       = n_q;
      num_d     = num_q;
      wr_addr_d = wr_addr_q;
      fb_clr    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               num_d     = num_samples;
               s_d       = '0;
               n_d       = '0;
               wr_addr_d = '0;
               fb_clr    = 1'b1;
               state_d   = (num_samples == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH:       state_d = S_FETCH_WAIT;
         S_FETCH_WAIT:  state_d = S_COMPUTE;
         S_COMPUTE:     state_d = S_ISSUE;
         S_ISSUE:       if (asic_ready) state_d = S_ACK_WAIT;
         S_ACK_WAIT:    if (!asic_ready) state_d = S_RESULT_WAIT;
         S_RESULT_WAIT: if (asic_ready) state_d = S_WRITE;
         S_WRITE: begin
            wr_addr_d = wr_addr_q + 32'd1;
            if (n_q < LAST_NODE) begin
               n_d     = n_q + 8'd1;
               state_d = S_FETCH;
            end else begin
               n_d = '0;
               if (s_q == num_q - ADDR_WIDTH'(1)) begin
                  state_d = S_DONE;
               end else begin
                  s_d     = s_q + ADDR_WIDTH'(1);
                  state_d = S_FETCH;
               end
            end
         end
         S_DONE:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they align with state_q
   always_comb begin
      sample_addr_d  = (state_d == S_FETCH) ? s_d : sample_addr_q;
      mask_addr_d    = (state_d == S_FETCH) ? n_d : mask_addr_q;
      asic_start_d   = (state_q == S_ISSUE) && asic_ready;
      asic_data_in_d = (state_q == S_COMPUTE) ? sat16 : asic_data_in_q;
      res_wr_en_d    = (state_d == S_WRITE);
      res_wr_addr_d  = (state_d == S_WRITE) ? wr_addr_q : 32'd0;
      res_wr_data_d  = (state_d == S_WRITE) ? asic_data_out : 16'd0;
      busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d         = (state_d == S_DONE);
   end

   assign sample_addr  = sample_addr_q;
   assign mask_addr    = mask_addr_q;
   assign asic_start   = asic_start_q;
   assign asic_data_in = asic_data_in_q;
   assign res_wr_en    = res_wr_en_q;
   assign res_wr_addr  = res_wr_addr_q;
   assign res_wr_data  = res_wr_data_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_dfr_reservoir_sequencer.sv
// Scoreboard bench: expected ASIC requests and reservoir writes are queued from a
// reference model when a run is launched and popped as the sequencer produces them.
module tb_dfr_reservoir_sequencer;

   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A: N=4, SHIFT=1
   logic          run = 1'b0;
   logic [AW-1:0] num_samples = '0;
   logic [AW-1:0] sample_addr;
   logic [15:0]   sample_data = '0;
   logic [7:0]    mask_addr;
   logic [15:0]   mask_data = '0;
   logic          asic_start;
   logic [15:0]   asic_data_in;
   logic          asic_ready;
   logic [15:0]   asic_data_out = '0;
   logic          res_wr_en;
   logic [31:0]   res_wr_addr;
   logic [15:0]   res_wr_data;
   logic          busy, done;

   // instance B: N=1, SHIFT=0
   logic          b_run = 1'b0;
   logic [AW-1:0] b_num_samples = '0;
   logic [AW-1:0] b_sample_addr;
   logic [15:0]   b_sample_data = 16'h0000;
   logic [7:0]    b_mask_addr;
   logic [15:0]   b_mask_data = 16'hFFFF;
   logic          b_asic_start;
   logic [15:0]   b_asic_data_in;
   logic          b_asic_ready;
   logic [15:0]   b_asic_data_out = '0;
   logic          b_res_wr_en;
   logic [31:0]   b_res_wr_addr;
   logic [15:0]   b_res_wr_data;
   logic          b_busy, b_done;

   dfr_reservoir_sequencer #(.NUM_VIRTUAL_NODES(4), .FEEDBACK_SHIFT(1), .ADDR_WIDTH(AW)) u_dut (
      .clk(clk), .rst(rst), .run(run), .num_samples(num_samples),
      .sample_addr(sample_addr), .sample_data(sample_data),
      .mask_addr(mask_addr), .mask_data(mask_data),
      .asic_start(asic_start), .asic_data_in(asic_data_in),
      .asic_ready(asic_ready), .asic_data_out(asic_data_out),
      .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
      .busy(busy), .done(done)
   );

   dfr_reservoir_sequencer #(.NUM_VIRTUAL_NODES(1), .FEEDBACK_SHIFT(0), .ADDR_WIDTH(AW)) u_dut_b (
      .clk(clk), .rst(rst), .run(b_run), .num_samples(b_num_samples),
      .sample_addr(b_sample_addr), .sample_data(b_sample_data),
      .mask_addr(b_mask_addr), .mask_data(b_mask_data),
      .asic_start(b_asic_start), .asic_data_in(b_asic_data_in),
      .asic_ready(b_asic_ready), .asic_data_out(b_asic_data_out),
      .res_wr_en(b_res_wr_en), .res_wr_addr(b_res_wr_addr), .res_wr_data(b_res_wr_data),
      .busy(b_busy), .done(b_done)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // sample / mask memories with one-cycle read latency
   logic [15:0] smem [2];
   logic [15:0] mmem [4];
   initial begin
      smem[0] = 16'h8000; smem[1] = 16'hFFFF;
      mmem[0] = 16'hFFFF; mmem[1] = 16'h8000; mmem[2] = 16'h0000; mmem[3] = 16'h4000;
   end
   always @(posedge clk) begin
      sample_data <= smem[sample_addr[0]];
      mask_data   <= mmem[mask_addr[1:0]];
   end

   // ASIC models: drop ready on a request, return a result 20 cycles later
   logic        a_rdy = 1'b1, force_low = 1'b0;
   logic [15:0] a_lat = '0;
   int          a_cnt = 0;
   assign asic_ready = a_rdy & ~force_low;
   always @(posedge clk) begin
      if (a_rdy && asic_start) begin
         a_lat <= asic_data_in; a_rdy <= 1'b0; a_cnt <= 20;
      end else if (!a_rdy) begin
         if (a_cnt == 0) begin
            asic_data_out <= a_lat + 16'd1; a_rdy <= 1'b1;
         end else a_cnt <= a_cnt - 1;
      end
   end

   logic b_rdy = 1'b1;
   int   b_cnt = 0;
   assign b_asic_ready = b_rdy;
   always @(posedge clk) begin
      if (b_rdy && b_asic_start) begin
         b_rdy <= 1'b0; b_cnt <= 20;
      end else if (!b_rdy) begin
         if (b_cnt == 0) begin
            b_asic_data_out <= 16'h1234; b_rdy <= 1'b1;
         end else b_cnt <= b_cnt - 1;
      end
   end

   logic [15:0] exp_din [$];
   logic [31:0] exp_wa  [$];
   logic [15:0] exp_wd  [$];
   logic [15:0] exp_bdin [$];

   function automatic void build_exp(input int ns);
      logic [15:0] fbm [4];
      logic [31:0] p;
      logic [16:0] sm;
      logic [15:0] d;
      for (int i = 0; i < 4; i++) fbm[i] = 16'd0;
      for (int s = 0; s < ns; s++)
         for (int n = 0; n < 4; n++) begin
            p  = 32'(smem[s % 2]) * 32'(mmem[n]);
            sm = 17'(p[31:16]) + 17'(fbm[n] >> 1);
            d  = sm[16] ? 16'hFFFF : sm[15:0];
            exp_din.push_back(d);
            exp_wa.push_back(32'(s * 4 + n));
            exp_wd.push_back(d + 16'd1);
            fbm[n] = d + 16'd1;
         end
   endfunction

   int n_start = 0, n_wr = 0, n_done = 0, n_busy = 0;
   int n_bwr = 0, n_bdone = 0;
   logic [15:0] e16;
   logic [31:0] e32;
   logic [15:0] eb;

   always @(negedge clk) begin
      if (!rst) begin
         if (asic_start) begin
            n_start++;
            $display("A start din=%h", asic_data_in);
            chk("start_rdy", 32'(asic_ready), 32'd1);
            if (exp_din.size() == 0) chk("din_unexp", 32'(exp_din.size()), 32'd1);
            else begin e16 = exp_din.pop_front(); chk("din", 32'(asic_data_in), 32'(e16)); end
         end
         if (res_wr_en) begin
            n_wr++;
            $display("A write addr=%0d data=%h", res_wr_addr, res_wr_data);
            if (exp_wa.size() == 0) chk("wr_unexp", 32'(exp_wa.size()), 32'd1);
            else begin
               e32 = exp_wa.pop_front(); chk("wr_addr", res_wr_addr, e32);
               e16 = exp_wd.pop_front(); chk("wr_data", 32'(res_wr_data), 32'(e16));
            end
         end
         if (done) n_done++;
         if (busy) n_busy++;
         if (b_asic_start) begin
            $display("B start din=%h", b_asic_data_in);
            if (exp_bdin.size() == 0) chk("b_din_unexp", 32'(exp_bdin.size()), 32'd1);
            else begin eb = exp_bdin.pop_front(); chk("b_din", 32'(b_asic_data_in), 32'(eb)); end
         end
         if (b_res_wr_en) begin
            $display("B write addr=%0d data=%h", b_res_wr_addr, b_res_wr_data);
            chk("b_wr_addr", b_res_wr_addr, 32'(n_bwr));
            chk("b_wr_data", 32'(b_res_wr_data), 32'h1234);
            n_bwr++;
         end
         if (b_done) n_bdone++;
      end
   end

   task automatic pulse_run(input logic [AW-1:0] ns);
      @(posedge clk); #1;
      num_samples = ns; run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic wait_done(input int base, input int limit, input string tag);
      int k = 0;
      while (n_done == base && k < limit) begin @(posedge clk); k++; end
      chk(tag, 32'(n_done - base), 32'd1);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_ctl"},  {28'd0, busy, done, asic_start, res_wr_en}, 32'd0);
      chk({tag, "_din"},  32'(asic_data_in), 32'd0);
      chk({tag, "_wa"},   res_wr_addr, 32'd0);
      chk({tag, "_wd"},   32'(res_wr_data), 32'd0);
      chk({tag, "_addr"}, {8'd0, sample_addr, mask_addr}, 32'd0);
   endtask

   int base_d, base_w, base_s, k;

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("rst");
      chk("b_rst", {28'd0, b_busy, b_done, b_asic_start, b_res_wr_en}, 32'd0);
      chk("b_rst_addr", {8'd0, b_sample_addr, b_mask_addr}, 32'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // main two-sample run with saturation
      base_d = n_done; base_w = n_wr;
      build_exp(2);
      pulse_run(16'd2);
      #1 chk("busy_run", 32'(busy), 32'd1);
      wait_done(base_d, 2000, "main_done");
      repeat (3) @(posedge clk);
      chk("main_writes", 32'(n_wr - base_w), 32'd8);
      chk("main_done_once", 32'(n_done - base_d), 32'd1);
      chk("main_sb_empty", 32'(exp_din.size() + exp_wa.size()), 32'd0);

      // zero samples
      base_d = n_done; base_w = n_wr; base_s = n_start; n_busy = 0;
      pulse_run(16'd0);
      wait_done(base_d, 6, "zero_done");
      repeat (2) @(posedge clk);
      chk("zero_busy", 32'(n_busy), 32'd0);
      chk("zero_io", 32'((n_wr - base_w) + (n_start - base_s)), 32'd0);

      // ready held low while the sequencer sits in ISSUE
      base_d = n_done; base_w = n_wr;
      build_exp(1);
      pulse_run(16'd1);
      k = 0;
      while (n_wr == base_w && k < 500) begin @(posedge clk); k++; end
      chk("hold_first_wr", 32'(n_wr - base_w), 32'd1);
      #1 force_low = 1'b1;
      base_s = n_start;
      repeat (50) @(posedge clk);
      chk("hold_no_start", 32'(n_start - base_s), 32'd0);
      #1 force_low = 1'b0;
      @(posedge clk);
      @(negedge clk); chk("hold_pulse", 32'(asic_start), 32'd1);
      @(negedge clk); chk("hold_pulse_end", 32'(asic_start), 32'd0);
      wait_done(base_d, 2000, "hold_done");
      repeat (2) @(posedge clk);
      chk("hold_sb_empty", 32'(exp_din.size() + exp_wa.size()), 32'd0);

      // run re-pulsed and num_samples changed mid-run
      base_d = n_done; base_w = n_wr;
      build_exp(2);
      pulse_run(16'd2);
      repeat (30) @(posedge clk);
      #1 num_samples = 16'd5; run = 1'b1;
      @(posedge clk); #1 run = 1'b0;
      wait_done(base_d, 3000, "midrun_done");
      repeat (40) @(posedge clk);
      chk("midrun_writes", 32'(n_wr - base_w), 32'd8);
      chk("midrun_done_once", 32'(n_done - base_d), 32'd1);

      // asynchronous reset during RESULT_WAIT, then a fresh single-sample run
      base_d = n_done; base_s = n_start;
      build_exp(2);
      pulse_run(16'd2);
      k = 0;
      while (n_start - base_s < 5 && k < 2000) begin @(posedge clk); k++; end
      chk("abort_reach", 32'(n_start - base_s), 32'd5);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_zero_outputs("abort");
      @(posedge clk); #1 rst = 1'b0;
      exp_din.delete(); exp_wa.delete(); exp_wd.delete();
      repeat (30) @(posedge clk);
      chk("abort_no_done", 32'(n_done - base_d), 32'd0);
      base_d = n_done;
      build_exp(1);
      pulse_run(16'd1);
      wait_done(base_d, 2000, "after_abort_done");
      repeat (2) @(posedge clk);
      chk("after_abort_sb", 32'(exp_din.size() + exp_wa.size()), 32'd0);

      // single node, no feedback shift, constant ASIC result
      exp_bdin.push_back(16'h0000);
      exp_bdin.push_back(16'h1234);
      exp_bdin.push_back(16'h1234);
      @(posedge clk); #1 b_num_samples = 16'd3; b_run = 1'b1;
      @(posedge clk); #1 b_run = 1'b0;
      k = 0;
      while (n_bdone == 0 && k < 1000) begin @(posedge clk); k++; end
      repeat (2) @(posedge clk);
      chk("b_done", 32'(n_bdone), 32'd1);
      chk("b_writes", 32'(n_bwr), 32'd3);
      chk("b_sb_empty", 32'(exp_bdin.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
